axi_lite_cmd_master: RTL and testbench
======================================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 30, AXI address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width (32 or 64).
REQ-003 Parameter COUNT_WIDTH, default 32, width of wait/poll counters.
REQ-004 Parameter POLL_GAP, default 1000, idle cycles between poll reads (POLL_GAP >= 0).
REQ-005 M_AXI_ACLK  in  1  single clock; all logic on its rising edge.
REQ-006 M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-007 cmd_valid / cmd_ready  in / out  1 each  command handshake.
REQ-008 cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=WAIT.
REQ-009 cmd_addr  in  ADDR_W  target address; cmd_data  in  DATA_W  write data or expected value.
REQ-010 cmd_mask  in  DATA_W  don't-care bits (1 = ignored) for READ compare and POLL.
REQ-011 cmd_count  in  COUNT_WIDTH  WAIT cycles, or POLL max attempts.
REQ-012 rsp_valid / rsp_ready  out / in  1 each  response handshake.
REQ-013 rsp_data  out  DATA_W  last read data (0 for WRITE/WAIT); rsp_err  out  2  0=OK, 1=SLVERR/DECERR, 2=compare mismatch, 3=poll timeout.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 Full AXI4-Lite master port M_AXI_AW*, W* (WSTRB all ones), B*, AR*, R*; AWPROT/ARPROT = 0.

Function
REQ-016 States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, GAP, WAIT, RSP.
REQ-017 cmd_ready = 1 only in IDLE; command fields are registered on the cmd_valid&&cmd_ready edge.
REQ-018 WRITE: AWVALID and WVALID assert together the cycle after acceptance; each deasserts independently on its own READY; BREADY asserts once both have handshaken.
REQ-019 AW and W handshakes in the same cycle or in either order go to WR_RESP; the B handshake goes to RSP with rsp_err=1 if BRESP[1] is set.
REQ-020 READ: ARVALID held until ARREADY, then RREADY=1 until RVALID; capture RDATA.
REQ-021 READ compare: mismatch when (RDATA | mask) != (cmd_data | mask); rsp_err=2 on mismatch; RRESP error (rsp_err=1) takes priority over mismatch.
REQ-022 POLL: repeat READ; on match -> RSP with OK; on mismatch, decrement attempts, wait POLL_GAP cycles in GAP, reissue.
REQ-023 POLL with attempts exhausted -> RSP, rsp_err=3, rsp_data = last read; cmd_count=0 is treated as 1 attempt.
REQ-024 POLL with RRESP error aborts immediately with rsp_err=1.
REQ-025 WAIT: stay cmd_count cycles in WAIT, then RSP; cmd_count=0 goes straight to RSP.
REQ-026 RSP: rsp_valid held with stable rsp_data/rsp_err until rsp_ready; handshake returns to IDLE; next command may be accepted the following cycle.
REQ-027 At most one AXI transaction outstanding; VALID never drops before READY (AXI stability).

Reset
REQ-028 On M_AXI_ARESETN low: state=IDLE, all VALID/READY outputs 0 except cmd_ready=1, rsp_data=0, rsp_err=0, busy=0, counters 0.
REQ-029 Reset mid-transaction abandons it immediately; no response is produced for the aborted command.

Structure
REQ-030 Shared package axi_cmd_pkg holds the op enum, rsp_err enum, state enum and the AXI resp codes.
REQ-031 Single module; no sub-module required; all outputs registered.

Verification
REQ-032 WRITE 0x0008 <- 1, slave AWREADY 2 cycles before WREADY -> one AW, one W beat, rsp OK, rsp_data=0.
REQ-033 READ 0x0100_0004, expected 300, mask 0, slave returns 300 -> rsp OK, rsp_data=300; slave returns 301 -> rsp_err=2.
REQ-034 POLL 0x0000, expected 0, count 5, POLL_GAP=4; slave returns 1,1,0 -> 3 AR handshakes 4+ cycles apart, rsp OK, rsp_data=0.
REQ-035 POLL count 2, slave always returns 1 -> exactly 2 reads, rsp_err=3, rsp_data=1.
REQ-036 WRITE with BRESP=2'b10 -> rsp_err=1; READ with RRESP=2'b11 and mismatched data -> rsp_err=1.
REQ-037 Assert reset while ARVALID high -> ARVALID=0, busy=0, cmd_ready=1 on the next clock edge, no rsp_valid.

Source files
------------

// File: rtl/axi_cmd_pkg.sv
// axi_cmd_pkg: command, response-error, FSM state and AXI response types for axi_lite_cmd_master
package axi_cmd_pkg;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_POLL, OP_WAIT} op_e;
  typedef enum logic [1:0] {ERR_OK, ERR_SLV, ERR_CMP, ERR_TMO} rsp_err_e;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_GAP, S_WAIT, S_RSP} state_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_e;
  function automatic logic resp_is_err(input resp_e r);
    return r == RESP_SLVERR || r == RESP_DECERR;
  endfunction
endpackage

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: executes WRITE/READ/POLL/WAIT commands as single AXI4-Lite transactions
//   cmd_*  : command handshake (op, addr, data/expected, don't-care mask, wait/attempt count)
//   rsp_*  : response handshake (last read data, error code)
//   M_AXI_*: AXI4-Lite master port, one transaction outstanding; busy high outside IDLE
module axi_lite_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 30,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int POLL_GAP = 1000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_mask,
  input  logic [COUNT_WIDTH-1:0]          cmd_count,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_err,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] GAP_N = COUNT_WIDTH'(POLL_GAP);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d, mask_q, mask_d, rsp_data_q, rsp_data_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, gap_q, gap_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d, cmd_ready_q, busy_q;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic r_err, r_match;
  assign r_err = resp_is_err(resp_e'(M_AXI_RRESP));
  assign r_match = (M_AXI_RDATA | mask_q) == (data_q | mask_q);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    awvalid_d = awvalid_q & ~M_AXI_AWREADY;
    wvalid_d = wvalid_q & ~M_AXI_WREADY;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d = op_e'(cmd_op);
        addr_d = cmd_addr;
        data_d = cmd_data;
        mask_d = cmd_mask;
        cnt_d = cmd_count;
        rsp_data_d = '0;
        rsp_err_d = ERR_OK;
        case (op_e'(cmd_op))
          OP_WRITE: begin
            state_d = S_WR;
            awvalid_d = 1'b1;
            wvalid_d = 1'b1;
          end
          OP_READ: begin
            state_d = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
          OP_POLL: begin
            state_d = S_RD_ADDR;
            arvalid_d = 1'b1;
            cnt_d = cmd_count == '0 ? ONE : cmd_count;
          end
          default: begin
            state_d = cmd_count == '0 ? S_RSP : S_WAIT;
            rsp_valid_d = cmd_count == '0;
          end
        endcase
      end
      // AW and W retire independently; B is only accepted once both are gone
      S_WR: if (!awvalid_d && !wvalid_d) begin
        state_d = S_WR_RESP;
        bready_d = 1'b1;
      end
      S_WR_RESP: if (M_AXI_BVALID) begin
        bready_d = 1'b0;
        state_d = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d = resp_is_err(resp_e'(M_AXI_BRESP)) ? ERR_SLV : ERR_OK;
      end
      S_RD_ADDR: if (M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = S_RD_DATA;
      end
      // a bus error wins over a compare result; a POLL retries until its attempts run out
      S_RD_DATA: if (M_AXI_RVALID) begin
        rready_d = 1'b0;
        rsp_data_d = M_AXI_RDATA;
        if (r_err || op_q == OP_READ || r_match || cnt_q <= ONE) begin
          state_d = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d = r_err ? ERR_SLV : r_match ? ERR_OK : op_q == OP_READ ? ERR_CMP : ERR_TMO;
        end else begin
          cnt_d = cnt_q - ONE;
          gap_d = GAP_N;
          state_d = GAP_N == '0 ? S_RD_ADDR : S_GAP;
          arvalid_d = GAP_N == '0;
        end
      end
      S_GAP: begin
        gap_d = gap_q - ONE;
        if (gap_q <= ONE) begin
          state_d = S_RD_ADDR;
          arvalid_d = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) begin
          state_d = S_RSP;
          rsp_valid_d = 1'b1;
        end
      end
      S_RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      op_q <= OP_WRITE;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= ERR_OK;
      cmd_ready_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      cmd_ready_q <= state_d == S_IDLE;
      busy_q <= state_d != S_IDLE;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign busy = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA = data_q;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_WVALID = wvalid_q;
  assign M_AXI_BREADY = bready_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY = rready_q;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed scoreboard bench with a simple AXI4-Lite slave model
module tb_axi_lite_cmd_master;
  localparam int GAP = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, busy;
  logic [1:0] cmd_op = '0, rsp_err;
  logic [29:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0, cmd_mask = '0, cmd_count = '0, rsp_data;
  logic [29:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = '0, rresp = '0, bresp_cfg = '0, rresp_cfg = '0;
  logic [31:0] rdata = '0;
  int aw_lat = 0, w_lat = 0, aw_age = 0, w_age = 0;
  logic ar_stall = 1'b0;
  int cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [29:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0] last_wdata = '0;
  int ar_cyc[$];
  logic [31:0] rd_vals[$];
  typedef struct {logic [31:0] d; logic [1:0] e;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0, lat = 0;

  axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(30), .C_M_AXI_DATA_WIDTH(32), .COUNT_WIDTH(32), .POLL_GAP(GAP)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial forever #5 clk = ~clk;

  // slave: drives on the falling edge from handshake history
  initial forever begin
    @(negedge clk);
    aw_age = awvalid ? aw_age + 1 : 0;
    w_age = wvalid ? w_age + 1 : 0;
    awready = awvalid && aw_age > aw_lat;
    wready = wvalid && w_age > w_lat;
    bvalid = aw_hs > b_hs && w_hs > b_hs;
    bresp = bresp_cfg;
    arready = arvalid && !ar_stall;
    rvalid = ar_hs > r_hs;
    rdata = rd_vals.size() > 0 ? rd_vals[0] : '0;
    rresp = rresp_cfg;
  end

  // monitor: counts handshakes on the rising edge; the last read value sticks
  initial forever begin
    @(posedge clk);
    cyc++;
    if (awvalid && awready) begin aw_hs++; last_awaddr = awaddr; end
    if (wvalid && wready) begin w_hs++; last_wdata = wdata; end
    if (bvalid && bready) b_hs++;
    if (arvalid && arready) begin ar_hs++; last_araddr = araddr; ar_cyc.push_back(cyc); end
    if (rvalid && rready) begin
      r_hs++;
      if (rd_vals.size() > 1) void'(rd_vals.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic [1:0] e);
    exp_q.push_back('{d: d, e: e});
  endtask

  task automatic send(input logic [1:0] op, input logic [29:0] a, input logic [31:0] d, input logic [31:0] m, input logic [31:0] c);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    cmd_mask = m;
    cmd_count = c;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int n = 0;
    exp_t e;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    lat = n;
    repeat (hold) @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '{d: 32'hdead_beef, e: 2'bxx};
    chk({tag, "_data"}, rsp_data, e.d);
    chk({tag, "_err"}, rsp_err, e.e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    int a0, w0, b0, seen, n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    // WRITE, AWREADY two cycles ahead of WREADY
    aw_lat = 0; w_lat = 2;
    a0 = aw_hs; w0 = w_hs; b0 = b_hs;
    expect_rsp(0, 0);
    send(2'd0, 30'h8, 32'h1, 0, 0);
    get_rsp("wr", 0);
    chk("wr_aw_count", aw_hs - a0, 1);
    chk("wr_w_count", w_hs - w0, 1);
    chk("wr_b_count", b_hs - b0, 1);
    chk("wr_awaddr", last_awaddr, 30'h8);
    chk("wr_wdata", last_wdata, 1);
    chk("wr_wstrb", wstrb, 4'hf);
    chk("wr_prot", {awprot, arprot}, 0);
    // READ match, with rsp_ready held off to check stability
    rd_vals = '{32'd300};
    a0 = ar_hs;
    expect_rsp(300, 0);
    send(2'd1, 30'h0100_0004, 300, 0, 0);
    get_rsp("rd_ok", 3);
    chk("rd_ar_count", ar_hs - a0, 1);
    chk("rd_araddr", last_araddr, 30'h0100_0004);
    rd_vals = '{32'd301};
    expect_rsp(301, 2);
    send(2'd1, 30'h0100_0004, 300, 0, 0);
    get_rsp("rd_mis", 0);
    // READ where only masked bits differ
    rd_vals = '{32'hF5};
    expect_rsp(32'hF5, 0);
    send(2'd1, 30'h20, 32'hF0, 32'h0F, 0);
    get_rsp("rd_mask", 0);
    // POLL succeeding on the third read
    rd_vals = '{32'd1, 32'd1, 32'd0};
    a0 = ar_hs;
    ar_cyc.delete();
    expect_rsp(0, 0);
    send(2'd2, 30'h0, 0, 0, 5);
    get_rsp("poll_ok", 0);
    chk("poll_ar_count", ar_hs - a0, 3);
    chk("poll_gap1", ar_cyc.size() >= 2 ? ar_cyc[1] - ar_cyc[0] : -1, GAP + 2);
    chk("poll_gap2", ar_cyc.size() >= 3 ? ar_cyc[2] - ar_cyc[1] : -1, GAP + 2);
    // POLL exhausting two attempts
    rd_vals = '{32'd1};
    a0 = ar_hs;
    expect_rsp(1, 3);
    send(2'd2, 30'h0, 0, 0, 2);
    get_rsp("poll_tmo", 0);
    chk("poll_tmo_reads", ar_hs - a0, 2);
    // POLL with count 0 behaves as a single attempt
    rd_vals = '{32'd7};
    a0 = ar_hs;
    expect_rsp(7, 3);
    send(2'd2, 30'h4, 0, 0, 0);
    get_rsp("poll_c0", 0);
    chk("poll_c0_reads", ar_hs - a0, 1);
    // error responses
    aw_lat = 1; w_lat = 0; bresp_cfg = 2'b10;
    expect_rsp(0, 1);
    send(2'd0, 30'h10, 32'h55, 0, 0);
    get_rsp("wr_slverr", 0);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    rd_vals = '{32'd5};
    expect_rsp(5, 1);
    send(2'd1, 30'h14, 300, 0, 0);
    get_rsp("rd_decerr", 0);
    rresp_cfg = 2'b00;
    // POLL aborts at once on a bus error
    rresp_cfg = 2'b10;
    rd_vals = '{32'd9};
    a0 = ar_hs;
    expect_rsp(9, 1);
    send(2'd2, 30'h18, 0, 0, 4);
    get_rsp("poll_err", 0);
    chk("poll_err_reads", ar_hs - a0, 1);
    rresp_cfg = 2'b00;
    // WAIT
    expect_rsp(0, 0);
    send(2'd3, 0, 0, 0, 0);
    get_rsp("wait0", 0);
    chk("wait0_lat", lat, 0);
    expect_rsp(0, 0);
    send(2'd3, 0, 32'h1234, 0, 5);
    chk("wait_busy", busy, 1);
    chk("wait_cmd_ready", cmd_ready, 0);
    get_rsp("wait5", 0);
    chk("wait5_lat", lat, 5);
    // reset while ARVALID is stalled
    ar_stall = 1'b1;
    rd_vals = '{32'd9};
    send(2'd1, 30'h40, 0, 0, 0);
    n = 0;
    while (!arvalid && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_arvalid_pre", arvalid, 1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ar_stall = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || arvalid) seen = 1;
    end
    chk("rst_mid_no_rsp", seen, 0);
    // normal operation after reset
    rd_vals = '{32'd42};
    expect_rsp(42, 0);
    send(2'd1, 30'h44, 42, 0, 0);
    get_rsp("rd_after_rst", 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
